// File: rtl/alu_acc_seq_pkg.sv
// Shared ALU definitions: op encoding, datapath width and the reference op function
// used by both the accumulator front end and the ALU formal check.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MUL2 = 2'd2,
    ZERO = 2'd3
  } alu_op_e;

  // All results wrap modulo 2^ALU_W; no carry or overflow is reported.
  function automatic logic [ALU_W-1:0] alu_apply(alu_op_e op,
                                                 logic [ALU_W-1:0] x,
                                                 logic [ALU_W-1:0] y);
    logic [ALU_W-1:0] r;
    case (op)
      ADD:     r = x + y;
      SUB:     r = x - y;
      MUL2:    r = {x[ALU_W-2:0], 1'b0};
      ZERO:    r = '0;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_acc_seq_if.sv
// Command and result handshake bundle between a command producer and the
// accumulator front end.
interface alu_acc_seq_if #(parameter int WIDTH = 4);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] acc;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, res_ready,
    input  cmd_ready, res_valid, res_data, acc
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, res_ready,
    output cmd_ready, res_valid, res_data, acc
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and empty
// are told apart by the MSB compare.
module alu_cmd_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator front end: buffers (op, operand) commands, executes them in order
// against the accumulator and emits each new accumulator value as a result beat.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_acc_seq_if.slave bus
);

  localparam int EW = 2 + WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic             fifo_full;
  logic             fifo_empty;
  logic             exec;
  logic [EW-1:0]    head;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] result;
  logic [1:0]       state;

  alu_cmd_fifo #(
    .W    (EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.cmd_valid),
    .push_data({bus.cmd_op, bus.cmd_operand}),
    .pop      (exec),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign result = alu_apply(alu_op_e'(head[EW-1 -: 2]), acc_q, head[WIDTH-1:0]);

  // DRAIN covers a pending result with nothing queued behind it.
  always_comb begin
    state = ST_IDLE;
    if (!fifo_empty && (!res_valid_q || bus.res_ready)) state = ST_RUN;
    else if (!fifo_empty)                               state = ST_STALL;
    else if (res_valid_q)                               state = ST_DRAIN;
  end

  assign exec = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          acc_q       <= result;
          res_q       <= result;
          res_valid_q <= 1'b1;
        end
        ST_DRAIN: begin
          if (bus.res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: directed vector table, backpressure and mid-stream reset
// sequences, then random handshake stress checked through a result scoreboard.
module tb_alu_acc_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_acc_seq_if #(.WIDTH(4)) bus ();

  alu_acc_seq #(.WIDTH(4), .DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] y;
    logic       rr;
    logic       exp_rv;
    logic [3:0] exp_data;
    logic [3:0] exp_acc;
  } vec_t;

  vec_t       vecs [12];
  logic [3:0] exp_q [$];
  logic [3:0] model_acc = 4'h0;
  int         checks = 0;
  int         failures = 0;
  int         accepted_cnt = 0;
  int         produced_cnt = 0;
  int         discarded_cnt = 0;

  function automatic logic [3:0] model(logic [1:0] op, logic [3:0] a, logic [3:0] y);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(y);
      2'd1:    r = int'(a) + 16 - int'(y);
      2'd2:    r = int'(a) * 2;
      default: r = 0;
    endcase
    return 4'(r % 16);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drives inputs, scores the handshakes that the next
  // rising edge will perform, then waits for the following falling edge.
  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic [3:0] y, input logic rr);
    logic [3:0] expv;
    bus.cmd_valid   = v;
    bus.cmd_op      = op;
    bus.cmd_operand = y;
    bus.res_ready   = rr;
    if (v && bus.cmd_ready) begin
      model_acc = model(op, model_acc, y);
      exp_q.push_back(model_acc);
      accepted_cnt++;
    end
    if (bus.res_valid && rr) begin
      produced_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        expv = exp_q.pop_front();
        checkOutput("scoreboard_result", int'(bus.res_data), int'(expv));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    int n;

    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 2'd0;
    bus.cmd_operand = 4'h0;
    bus.res_ready   = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_acc", int'(bus.acc), 0);
    checkOutput("reset_res_valid", int'(bus.res_valid), 0);
    checkOutput("reset_res_data", int'(bus.res_data), 0);
    checkOutput("reset_cmd_ready", int'(bus.cmd_ready), 1);

    vecs[0]  = '{1'b1, 2'd0, 4'd5, 1'b1, 1'b0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 2'd1, 4'd7, 1'b1, 1'b0, 4'h0, 4'h0};
    vecs[2]  = '{1'b1, 2'd2, 4'd9, 1'b1, 1'b1, 4'h5, 4'h5};
    vecs[3]  = '{1'b1, 2'd0, 4'd3, 1'b1, 1'b1, 4'hE, 4'hE};
    vecs[4]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'hC, 4'hC};
    vecs[5]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'hF, 4'hF};
    vecs[6]  = '{1'b1, 2'd0, 4'd1, 1'b1, 1'b0, 4'hF, 4'hF};
    vecs[7]  = '{1'b1, 2'd1, 4'd1, 1'b1, 1'b0, 4'hF, 4'hF};
    vecs[8]  = '{1'b1, 2'd3, 4'd9, 1'b1, 1'b1, 4'h0, 4'h0};
    vecs[9]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'hF, 4'hF};
    vecs[10] = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 4'h0, 4'h0};

    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("vec%0d_res_valid", i), int'(bus.res_valid), int'(vecs[i].exp_rv));
      checkOutput($sformatf("vec%0d_res_data", i), int'(bus.res_data), int'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_acc", i), int'(bus.acc), int'(vecs[i].exp_acc));
      checkOutput($sformatf("vec%0d_cmd_ready", i), int'(bus.cmd_ready), 1);
      applyStimulus(vecs[i].v, vecs[i].op, vecs[i].y, vecs[i].rr);
    end

    // Full backpressure: FIFO plus result register hold DEPTH+1 commands.
    base = accepted_cnt;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'd0, 4'd1, 1'b0);
    checkOutput("bp_accepted", accepted_cnt - base, 5);
    checkOutput("bp_cmd_ready", int'(bus.cmd_ready), 0);
    checkOutput("bp_res_valid", int'(bus.res_valid), 1);
    checkOutput("bp_res_data", int'(bus.res_data), 1);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);
    checkOutput("bp_hold_data", int'(bus.res_data), 1);
    checkOutput("bp_hold_valid", int'(bus.res_valid), 1);
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
      n++;
    end
    checkOutput("bp_drain_left", exp_q.size(), 0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("bp_cmd_ready_after", int'(bus.cmd_ready), 1);
    checkOutput("bp_res_valid_after", int'(bus.res_valid), 0);
    checkOutput("bp_acc_after", int'(bus.acc), 5);

    // Reset between clock edges with commands and a result in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 4'd2, 1'b0);
    bus.cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_acc", int'(bus.acc), 0);
    checkOutput("midrst_res_valid", int'(bus.res_valid), 0);
    checkOutput("midrst_res_data", int'(bus.res_data), 0);
    checkOutput("midrst_cmd_ready", int'(bus.cmd_ready), 1);
    discarded_cnt += exp_q.size();
    exp_q.delete();
    model_acc = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("postrst_res_valid", int'(bus.res_valid), 0);
    checkOutput("postrst_acc", int'(bus.acc), 0);

    // Random handshake stress.
    base = accepted_cnt;
    n = 0;
    while ((accepted_cnt - base) < 1000 && n < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
      n++;
    end
    checkOutput("stress_accepted", (accepted_cnt - base) >= 1000, 1);
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
      n++;
    end
    checkOutput("stress_drain_left", exp_q.size(), 0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("stress_res_valid_end", int'(bus.res_valid), 0);
    checkOutput("stress_acc_end", int'(bus.acc), int'(model_acc));
    checkOutput("beat_count", produced_cnt + discarded_cnt, accepted_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
